seq_arb: RTL and testbench

SEQ_ARB -- requirements
Module: seq_arb

---
 rtl/seq_arb_if.sv | 28 ++
 rtl/seq_arb.sv | 123 ++++++++++++
 tb/tb_seq_arb.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/seq_arb_if.sv
// seq_arb_if: bundles the request/data/grant/status signals of seq_arb.
//   req  [1:0] : level-held requests, bit k = channel k
//   x0, x1     : serial data per channel
//   gnt  [1:0] : one-hot registered grant
//   z          : one-cycle pattern-match pulse
//   done       : one-cycle end-of-burst pulse
//   cnt0, cnt1 : saturating per-channel match counters
// master drives req/x and observes status; slave is the arbiter side.
interface seq_arb_if;
  logic [1:0] req;
  logic       x0;
  logic       x1;
  logic [1:0] gnt;
  logic       z;
  logic       done;
  logic [3:0] cnt0;
  logic [3:0] cnt1;

  modport master (
    output req, x0, x1,
    input  gnt, z, done, cnt0, cnt1
  );

  modport slave (
    input  req, x0, x1,
    output gnt, z, done, cnt0, cnt1
  );
endinterface

// File: rtl/seq_arb.sv
// seq_arb: two-channel round-robin arbiter that, while a channel holds the
// grant, shifts in its serial data and flags occurrences of PAT.
//   clk   : sole clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : seq_arb_if.slave (req, x0, x1 in; gnt, z, done, cnt0, cnt1 out)
// A grant lasts up to BURST samples, ends early if the granted request drops,
// and is always followed by one FLUSH cycle (done=1) and one IDLE cycle.
module seq_arb #(
  parameter logic [3:0]  PAT   = 4'b0101,
  parameter int unsigned BURST = 8
) (
  input logic       clk,
  input logic       reset,
  seq_arb_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StGnt0, StGnt1, StFlush} state_e;

  state_e     state_q, state_d;
  logic [3:0] sr_q, sr_d;
  logic [3:0] bcnt_q, bcnt_d;
  logic [3:0] cnt0_q, cnt0_d;
  logic [3:0] cnt1_q, cnt1_d;
  logic       last_q, last_d;  // channel served most recently
  logic       z_q, z_d;
  logic       done_q, done_d;
  logic [1:0] gnt_q, gnt_d;

  logic       ch;
  logic       smp_x;
  logic [3:0] win;
  logic [3:0] bcnt_inc;
  logic       match;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    bcnt_d  = bcnt_q;
    cnt0_d  = cnt0_q;
    cnt1_d  = cnt1_q;
    last_d  = last_q;
    z_d     = 1'b0;

    ch       = (state_q == StGnt1);
    smp_x    = ch ? bus.x1 : bus.x0;
    win      = {sr_q[2:0], smp_x};
    bcnt_inc = bcnt_q + 4'd1;
    // Need three earlier bits in this burst before the window is valid.
    match    = (win == PAT) && (bcnt_q >= 4'd3);

    unique case (state_q)
      StIdle: begin
        // Channel 1 wins alone, or on contention when channel 0 went last.
        if (bus.req[1] && (!bus.req[0] || !last_q)) begin
          state_d = StGnt1;
          sr_d    = 4'd0;
          bcnt_d  = 4'd0;
        end else if (bus.req[0]) begin
          state_d = StGnt0;
          sr_d    = 4'd0;
          bcnt_d  = 4'd0;
        end
      end
      StGnt0, StGnt1: begin
        if (!bus.req[ch]) begin
          state_d = StFlush;
          last_d  = ch;
        end else begin
          sr_d   = win;
          bcnt_d = bcnt_inc;
          z_d    = match;
          if (match) begin
            if (ch) begin
              if (cnt1_q != 4'hf) cnt1_d = cnt1_q + 4'd1;
            end else begin
              if (cnt0_q != 4'hf) cnt0_d = cnt0_q + 4'd1;
            end
          end
          if (bcnt_inc == 4'(BURST)) begin
            state_d = StFlush;
            last_d  = ch;
          end
        end
      end
      StFlush: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    gnt_d  = {state_d == StGnt1, state_d == StGnt0};
    done_d = (state_d == StFlush);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      sr_q    <= 4'd0;
      bcnt_q  <= 4'd0;
      cnt0_q  <= 4'd0;
      cnt1_q  <= 4'd0;
      last_q  <= 1'b1;  // so the first contention goes to channel 0
      z_q     <= 1'b0;
      done_q  <= 1'b0;
      gnt_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      bcnt_q  <= bcnt_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
      last_q  <= last_d;
      z_q     <= z_d;
      done_q  <= done_d;
      gnt_q   <= gnt_d;
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.z    = z_q;
  assign bus.done = done_q;
  assign bus.cnt0 = cnt0_q;
  assign bus.cnt1 = cnt1_q;

endmodule

// File: tb/tb_seq_arb.sv
// tb_seq_arb: directed scenarios plus randomized traffic for seq_arb, checked
// cycle by cycle against a burst-level reference model.
module tb_seq_arb;
  localparam logic [3:0]  PAT   = 4'b0101;
  localparam int unsigned BURST = 8;

  logic clk = 1'b0;
  logic reset;

  seq_arb_if bus ();

  seq_arb #(
    .PAT   (PAT),
    .BURST (BURST)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: who owns the bus, the bits sampled this burst, counters.
  int         m_owner;  // -1 = nobody
  bit         m_flush;
  int         m_last;
  bit         m_hist[$];
  int         m_cnt[2];
  logic [1:0] e_gnt;
  logic       e_z;
  logic       e_done;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  function automatic void model_reset();
    m_owner = -1;
    m_flush = 1'b0;
    m_last  = 1;
    m_hist.delete();
    m_cnt   = '{0, 0};
    e_gnt   = 2'b00;
    e_z     = 1'b0;
    e_done  = 1'b0;
  endfunction

  function automatic void model_edge(input logic [1:0] r, input logic a, input logic b);
    int         k;
    int         n;
    logic [3:0] tail;
    e_z = 1'b0;
    if (m_flush) begin
      m_flush = 1'b0;
    end else if (m_owner >= 0) begin
      k = m_owner;
      if (!r[k]) begin
        m_flush = 1'b1;
        m_last  = k;
        m_owner = -1;
      end else begin
        m_hist.push_back((k == 1) ? b : a);
        n = m_hist.size();
        if (n >= 4) begin
          tail = {m_hist[n-4], m_hist[n-3], m_hist[n-2], m_hist[n-1]};
          if (tail == PAT) begin
            e_z = 1'b1;
            if (m_cnt[k] < 15) m_cnt[k]++;
          end
        end
        if (n == int'(BURST)) begin
          m_flush = 1'b1;
          m_last  = k;
          m_owner = -1;
        end
      end
    end else if (r != 2'b00) begin
      if (r == 2'b11) m_owner = (m_last == 0) ? 1 : 0;
      else            m_owner = r[1] ? 1 : 0;
      m_hist.delete();
    end
    e_gnt  = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
    e_done = m_flush;
  endfunction

  // Apply inputs away from the edge, clock once, then compare every output.
  task automatic step(input logic [1:0] r, input logic a, input logic b);
    bus.req = r;
    bus.x0  = a;
    bus.x1  = b;
    @(posedge clk);
    if (!reset) model_reset();
    else        model_edge(r, a, b);
    #1;
    check("gnt",  int'(bus.gnt),  int'(e_gnt));
    check("z",    int'(bus.z),    int'(e_z));
    check("done", int'(bus.done), int'(e_done));
    check("cnt0", int'(bus.cnt0), m_cnt[0]);
    check("cnt1", int'(bus.cnt1), m_cnt[1]);
  endtask

  task automatic rand_step();
    step(2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
  endtask

  // Drop reset between edges and confirm outputs clear without a clock edge.
  task automatic async_reset();
    reset = 1'b0;
    #1;
    check("async_gnt",  int'(bus.gnt),  0);
    check("async_z",    int'(bus.z),    0);
    check("async_done", int'(bus.done), 0);
    check("async_cnt0", int'(bus.cnt0), 0);
    check("async_cnt1", int'(bus.cnt1), 0);
    model_reset();
  endtask

  task automatic apply_reset();
    async_reset();
    for (int i = 0; i < 3; i++) rand_step();
    reset = 1'b1;
  endtask

  logic [7:0] pat30;
  logic [7:0] pat33;
  logic [1:0] rq;

  initial begin
    reset   = 1'b0;
    bus.req = 2'b00;
    bus.x0  = 1'b0;
    bus.x1  = 1'b0;
    model_reset();
    #2;

    // Reset held with random activity: outputs stay cleared.
    for (int i = 0; i < 6; i++) rand_step();
    reset = 1'b1;

    // Single channel 0 burst: matches after bits 4 and 6.
    pat30 = 8'b01010110;
    step(2'b01, 1'b0, 1'b0);
    check("burst_gnt0", int'(bus.gnt), 1);
    for (int i = 7; i >= 0; i--) step(2'b01, pat30[i], 1'b0);
    check("burst_cnt0", int'(bus.cnt0), 2);
    check("burst_done", int'(bus.done), 1);
    step(2'b00, 1'b0, 1'b0);
    step(2'b00, 1'b0, 1'b0);

    // Simultaneous requests after reset: channel 0 first, then alternation.
    apply_reset();
    step(2'b11, 1'b0, 1'b0);
    check("rr_first", int'(bus.gnt), 1);
    for (int i = 0; i < 30; i++) step(2'b11, 1'b0, 1'b0);
    step(2'b00, 1'b0, 1'b0);
    step(2'b00, 1'b0, 1'b0);

    // Channel 1 aborts after three samples.
    apply_reset();
    step(2'b10, 1'b0, 1'b0);
    step(2'b10, 1'b0, 1'b0);
    step(2'b10, 1'b0, 1'b1);
    step(2'b10, 1'b0, 1'b0);
    step(2'b00, 1'b0, 1'b1);
    check("abort_done", int'(bus.done), 1);
    check("abort_cnt1", int'(bus.cnt1), 0);
    step(2'b00, 1'b0, 1'b0);

    // Eight bursts of 01010101 on channel 0: counter saturates.
    pat33 = 8'b01010101;
    for (int b = 0; b < 8; b++) begin
      step(2'b01, 1'b0, 1'b0);
      for (int i = 7; i >= 0; i--) step(2'b01, pat33[i], 1'b0);
      step(2'b00, 1'b0, 1'b0);
      step(2'b00, 1'b0, 1'b0);
    end
    check("sat_cnt0", int'(bus.cnt0), 15);

    // Reset during a channel 1 burst at sample 5, then re-grant channel 1.
    step(2'b10, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(2'b10, 1'b0, 1'($urandom));
    async_reset();
    step(2'b10, 1'b0, 1'b1);
    reset = 1'b1;
    step(2'b10, 1'b0, 1'b0);
    check("post_reset_gnt1", int'(bus.gnt), 2);
    for (int i = 0; i < 12; i++) step(2'b10, 1'b0, 1'($urandom));

    // Random traffic: level-held requests that change occasionally.
    rq = 2'b00;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 7) == 0) rq = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 399) == 0) begin
        async_reset();
        step(rq, 1'($urandom), 1'($urandom));
        reset = 1'b1;
      end else begin
        step(rq, 1'($urandom), 1'($urandom));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
